// File: rtl/bram_arb_pkg.sv
// rtl/bram_arb_pkg.sv - shared types for the BRAM port arbiter
package bram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOST  = 2'd1,
        CORE  = 2'd2,
        DRAIN = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic valid;
        logic host;
    } rd_tag_t;

    localparam int DROP_COUNT_W = 8;

endpackage

// File: rtl/bram_port_arbiter_rd_tag_pipe.sv
// rtl/bram_port_arbiter_rd_tag_pipe.sv - read tag shift register that follows BRAM read latency
module rd_tag_pipe
    import bram_arb_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic load_valid,
    input  logic load_host,
    output logic tail_valid,
    output logic tail_host,
    output logic empty
);

    rd_tag_t [STAGES-1:0] pipe;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pipe <= '0;
        end else begin
            pipe[0] <= '{valid: load_valid, host: load_host & load_valid};
            for (int i = 1; i < STAGES; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    always_comb begin
        empty = 1'b1;
        for (int i = 0; i < STAGES; i++) begin
            if (pipe[i].valid) begin
                empty = 1'b0;
            end
        end
    end

    assign tail_valid = pipe[STAGES-1].valid;
    assign tail_host  = pipe[STAGES-1].host;

endmodule

// File: rtl/bram_port_arbiter.sv
// rtl/bram_port_arbiter.sv - host/core arbiter for one BRAM port; drop counter under BRAM_ARB_DROP_CHECK_EN
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int DEPTH        = 16384,
    parameter int WIDTH        = 64,
    parameter int READ_LATENCY = 2,
    localparam int AW          = $clog2(DEPTH)
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    host_busy_in,
    input  logic [AW-1:0]           host_addr_in,
    input  logic [WIDTH-1:0]        host_wdata_in,
    input  logic                    host_we_in,
    input  logic                    host_re_in,
    output logic [WIDTH-1:0]        host_rdata_out,
    output logic                    host_rvalid_out,
    input  logic                    core_req_in,
    output logic                    core_gnt_out,
    input  logic [AW-1:0]           core_addr_in,
    input  logic [WIDTH-1:0]        core_wdata_in,
    input  logic                    core_we_in,
    input  logic                    core_re_in,
    output logic [WIDTH-1:0]        core_rdata_out,
    output logic                    core_rvalid_out,
    output logic [AW-1:0]           bram_addr_out,
    output logic [WIDTH-1:0]        bram_wdata_out,
    output logic                    bram_we_out,
    output logic                    bram_en_out,
    input  logic [WIDTH-1:0]        bram_rdata_in,
    output logic                    drop_err_out,
    output logic [DROP_COUNT_W-1:0] drop_count_out
);

    arb_state_t state, state_nxt;

    logic host_owns, core_owns, core_ok;
    logic host_wr, host_rd, core_wr, core_rd;
    logic rd_issue, in_flight;
    logic pipe_empty, tail_valid, tail_host;

    // Write wins over a simultaneous read, so a read is only tagged when we is low.
    always_comb begin
        host_owns = (state == HOST);
        core_owns = (state == CORE);
        core_ok   = core_owns & core_req_in;
        host_wr   = host_owns & host_we_in;
        host_rd   = host_owns & host_re_in & ~host_we_in;
        core_wr   = core_ok & core_we_in;
        core_rd   = core_ok & core_re_in & ~core_we_in;
        rd_issue  = host_rd | core_rd;
        in_flight = ~pipe_empty | rd_issue;
    end

    rd_tag_pipe #(
        .STAGES(READ_LATENCY)
    ) u_tag_pipe (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .load_valid(rd_issue),
        .load_host (host_rd),
        .tail_valid(tail_valid),
        .tail_host (tail_host),
        .empty     (pipe_empty)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (host_busy_in) begin
                    state_nxt = in_flight ? DRAIN : HOST;
                end else if (core_req_in) begin
                    state_nxt = CORE;
                end
            end
            HOST: begin
                if (!host_busy_in) begin
                    state_nxt = in_flight ? DRAIN : IDLE;
                end
            end
            CORE: begin
                // The core loses its grant immediately; its outstanding reads finish in DRAIN.
                if (host_busy_in) begin
                    state_nxt = DRAIN;
                end else if (!core_req_in) begin
                    state_nxt = IDLE;
                end
            end
            DRAIN: begin
                if (!in_flight) begin
                    state_nxt = host_busy_in ? HOST : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        core_gnt_out   = core_owns;
        bram_addr_out  = '0;
        bram_wdata_out = '0;
        bram_we_out    = 1'b0;
        bram_en_out    = 1'b0;
        if (host_owns) begin
            bram_addr_out  = host_addr_in;
            bram_wdata_out = host_wdata_in;
            bram_we_out    = host_wr;
            bram_en_out    = host_wr | host_rd;
        end else if (core_owns) begin
            bram_addr_out  = core_addr_in;
            bram_wdata_out = core_wdata_in;
            bram_we_out    = core_wr;
            bram_en_out    = core_wr | core_rd;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            host_rdata_out  <= '0;
            host_rvalid_out <= 1'b0;
            core_rdata_out  <= '0;
            core_rvalid_out <= 1'b0;
        end else begin
            host_rvalid_out <= tail_valid & tail_host;
            core_rvalid_out <= tail_valid & ~tail_host;
            if (tail_valid && tail_host) begin
                host_rdata_out <= bram_rdata_in;
            end
            if (tail_valid && !tail_host) begin
                core_rdata_out <= bram_rdata_in;
            end
        end
    end

`ifdef BRAM_ARB_DROP_CHECK_EN
    logic host_drop;

    assign host_drop = ~host_owns & (host_we_in | host_re_in);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            drop_err_out   <= 1'b0;
            drop_count_out <= '0;
        end else if (host_drop) begin
            drop_err_out <= 1'b1;
            if (drop_count_out != {DROP_COUNT_W{1'b1}}) begin
                drop_count_out <= drop_count_out + 1'b1;
            end
        end
    end
`else
    assign drop_err_out   = 1'b0;
    assign drop_count_out = '0;
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb/tb_bram_port_arbiter.sv - directed bench for bram_port_arbiter with a 2-cycle BRAM model
module tb_bram_port_arbiter;

    localparam int AW = 14;
    localparam int W  = 64;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          host_busy_in;
    logic [AW-1:0] host_addr_in;
    logic [W-1:0]  host_wdata_in;
    logic          host_we_in;
    logic          host_re_in;
    logic [W-1:0]  host_rdata_out;
    logic          host_rvalid_out;
    logic          core_req_in;
    logic          core_gnt_out;
    logic [AW-1:0] core_addr_in;
    logic [W-1:0]  core_wdata_in;
    logic          core_we_in;
    logic          core_re_in;
    logic [W-1:0]  core_rdata_out;
    logic          core_rvalid_out;
    logic [AW-1:0] bram_addr_out;
    logic [W-1:0]  bram_wdata_out;
    logic          bram_we_out;
    logic          bram_en_out;
    logic [W-1:0]  bram_rdata_in;
    logic          drop_err_out;
    logic [7:0]    drop_count_out;

    bram_port_arbiter #(
        .DEPTH(16384),
        .WIDTH(W),
        .READ_LATENCY(2)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .host_busy_in   (host_busy_in),
        .host_addr_in   (host_addr_in),
        .host_wdata_in  (host_wdata_in),
        .host_we_in     (host_we_in),
        .host_re_in     (host_re_in),
        .host_rdata_out (host_rdata_out),
        .host_rvalid_out(host_rvalid_out),
        .core_req_in    (core_req_in),
        .core_gnt_out   (core_gnt_out),
        .core_addr_in   (core_addr_in),
        .core_wdata_in  (core_wdata_in),
        .core_we_in     (core_we_in),
        .core_re_in     (core_re_in),
        .core_rdata_out (core_rdata_out),
        .core_rvalid_out(core_rvalid_out),
        .bram_addr_out  (bram_addr_out),
        .bram_wdata_out (bram_wdata_out),
        .bram_we_out    (bram_we_out),
        .bram_en_out    (bram_en_out),
        .bram_rdata_in  (bram_rdata_in),
        .drop_err_out   (drop_err_out),
        .drop_count_out (drop_count_out)
    );

    always #5 clk_in = ~clk_in;

    // BRAM model: two-cycle registered read, plus a preload port for the bench.
    logic [W-1:0]  mem [16384];
    logic [W-1:0]  rd_s1;
    logic          pl_we = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [W-1:0]  pl_data = '0;

    always @(posedge clk_in) begin
        if (pl_we) begin
            mem[pl_addr] <= pl_data;
        end else if (bram_en_out && bram_we_out) begin
            mem[bram_addr_out] <= bram_wdata_out;
        end
        rd_s1         <= mem[bram_addr_out];
        bram_rdata_in <= rd_s1;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [W-1:0] d);
        pl_we   = 1'b1;
        pl_addr = a;
        pl_data = d;
        tick();
        pl_we = 1'b0;
    endtask

    task automatic clr_inputs();
        host_busy_in  = 1'b0;
        host_addr_in  = '0;
        host_wdata_in = '0;
        host_we_in    = 1'b0;
        host_re_in    = 1'b0;
        core_req_in   = 1'b0;
        core_addr_in  = '0;
        core_wdata_in = '0;
        core_we_in    = 1'b0;
        core_re_in    = 1'b0;
    endtask

    task automatic do_reset();
        clr_inputs();
        rst_in = 1'b1;
        tick();
        tick();
        rst_in = 1'b0;
    endtask

    typedef struct packed {
        logic          hb;
        logic          hwe;
        logic          hre;
        logic [AW-1:0] ha;
        logic          creq;
        logic          cwe;
        logic          cre;
        logic [AW-1:0] ca;
        logic          e_gnt;
        logic          e_en;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic          e_hrv;
    } vec_t;

    vec_t vt [12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int pulses;
        int wes;

        // hb hwe hre ha | creq cwe cre ca | gnt en we addr hrv
        vt[0]  = '{1'b0, 1'b0, 1'b0, 14'd0, 1'b0, 1'b0, 1'b0, 14'd0, 1'b0, 1'b0, 1'b0, 14'd0, 1'b0};
        vt[1]  = '{1'b0, 1'b0, 1'b0, 14'd0, 1'b1, 1'b0, 1'b1, 14'd3, 1'b0, 1'b0, 1'b0, 14'd0, 1'b0};
        vt[2]  = '{1'b0, 1'b0, 1'b0, 14'd0, 1'b1, 1'b1, 1'b0, 14'd9, 1'b1, 1'b1, 1'b1, 14'd9, 1'b0};
        vt[3]  = '{1'b0, 1'b0, 1'b0, 14'd0, 1'b1, 1'b1, 1'b1, 14'd4, 1'b1, 1'b1, 1'b1, 14'd4, 1'b0};
        vt[4]  = '{1'b0, 1'b0, 1'b0, 14'd0, 1'b0, 1'b0, 1'b0, 14'd0, 1'b1, 1'b0, 1'b0, 14'd0, 1'b0};
        vt[5]  = '{1'b1, 1'b1, 1'b0, 14'd2, 1'b0, 1'b0, 1'b0, 14'd0, 1'b0, 1'b0, 1'b0, 14'd0, 1'b0};
        vt[6]  = '{1'b1, 1'b0, 1'b1, 14'd7, 1'b1, 1'b0, 1'b0, 14'd0, 1'b0, 1'b1, 1'b0, 14'd7, 1'b0};
        vt[7]  = '{1'b0, 1'b0, 1'b0, 14'd0, 1'b0, 1'b0, 1'b0, 14'd0, 1'b0, 1'b0, 1'b0, 14'd0, 1'b0};
        vt[8]  = '{1'b0, 1'b0, 1'b0, 14'd0, 1'b1, 1'b0, 1'b0, 14'd0, 1'b0, 1'b0, 1'b0, 14'd0, 1'b0};
        vt[9]  = '{1'b0, 1'b0, 1'b0, 14'd0, 1'b1, 1'b0, 1'b0, 14'd0, 1'b0, 1'b0, 1'b0, 14'd0, 1'b1};
        vt[10] = '{1'b0, 1'b0, 1'b0, 14'd0, 1'b1, 1'b0, 1'b0, 14'd0, 1'b0, 1'b0, 1'b0, 14'd0, 1'b0};
        vt[11] = '{1'b0, 1'b0, 1'b0, 14'd0, 1'b1, 1'b0, 1'b1, 14'd5, 1'b1, 1'b1, 1'b0, 14'd5, 1'b0};

        clr_inputs();
        rst_in = 1'b1;
        preload(14'd5, 64'hDEAD);
        preload(14'd1, 64'h11);
        preload(14'd2, 64'h22);
        preload(14'd7, 64'hAAAA);
        preload(14'd20, 64'h5555_0000);
        rst_in = 1'b0;

        chk("rst_gnt", 64'(core_gnt_out), 64'd0);
        chk("rst_hrv", 64'(host_rvalid_out), 64'd0);
        chk("rst_crv", 64'(core_rvalid_out), 64'd0);
        chk("rst_hrdata", host_rdata_out, 64'd0);
        chk("rst_crdata", core_rdata_out, 64'd0);
        chk("rst_en", 64'(bram_en_out), 64'd0);
        chk("rst_drop_err", 64'(drop_err_out), 64'd0);
        chk("rst_drop_cnt", 64'(drop_count_out), 64'd0);

        for (int i = 0; i < 12; i++) begin
            host_busy_in  = vt[i].hb;
            host_we_in    = vt[i].hwe;
            host_re_in    = vt[i].hre;
            host_addr_in  = vt[i].ha;
            core_req_in   = vt[i].creq;
            core_we_in    = vt[i].cwe;
            core_re_in    = vt[i].cre;
            core_addr_in  = vt[i].ca;
            core_wdata_in = 64'hC0DE;
            #1;
            chk($sformatf("v%0d_gnt", i), 64'(core_gnt_out), 64'(vt[i].e_gnt));
            chk($sformatf("v%0d_en", i), 64'(bram_en_out), 64'(vt[i].e_en));
            chk($sformatf("v%0d_we", i), 64'(bram_we_out), 64'(vt[i].e_we));
            chk($sformatf("v%0d_addr", i), 64'(bram_addr_out), 64'(vt[i].e_addr));
            chk($sformatf("v%0d_hrv", i), 64'(host_rvalid_out), 64'(vt[i].e_hrv));
            tick();
        end
`ifdef BRAM_ARB_DROP_CHECK_EN
        chk("vec_drop_cnt", 64'(drop_count_out), 64'd1);
`else
        chk("vec_drop_cnt", 64'(drop_count_out), 64'd0);
`endif

        // Core read of addr 5 returns 3 cycles after the strobe.
        do_reset();
        core_req_in = 1'b1;
        tick();
        core_re_in   = 1'b1;
        core_addr_in = 14'd5;
        tick();
        core_re_in = 1'b0;
        chk("t1_crv_c1", 64'(core_rvalid_out), 64'd0);
        tick();
        chk("t1_crv_c2", 64'(core_rvalid_out), 64'd0);
        tick();
        chk("t1_crv_c3", 64'(core_rvalid_out), 64'd1);
        chk("t1_crdata", core_rdata_out, 64'hDEAD);
        chk("t1_hrv", 64'(host_rvalid_out), 64'd0);
        tick();
        chk("t1_crv_c4", 64'(core_rvalid_out), 64'd0);

        // Two core reads, then the host takes over through DRAIN.
        do_reset();
        core_req_in = 1'b1;
        tick();
        core_re_in   = 1'b1;
        core_addr_in = 14'd1;
        tick();
        core_addr_in = 14'd2;
        tick();
        chk("t2_gnt_before", 64'(core_gnt_out), 64'd1);
        core_re_in    = 1'b0;
        host_busy_in  = 1'b1;
        host_we_in    = 1'b1;
        host_addr_in  = 14'd100;
        host_wdata_in = 64'h77;
        tick();
        chk("t2_gnt_drop", 64'(core_gnt_out), 64'd0);
        chk("t2_drain_en1", 64'(bram_en_out), 64'd0);
        chk("t2_rv1", 64'(core_rvalid_out), 64'd1);
        chk("t2_rdata1", core_rdata_out, 64'h11);
        tick();
        chk("t2_drain_en2", 64'(bram_en_out), 64'd0);
        chk("t2_rv2", 64'(core_rvalid_out), 64'd1);
        chk("t2_rdata2", core_rdata_out, 64'h22);
        tick();
        chk("t2_host_en", 64'(bram_en_out), 64'd1);
        chk("t2_host_we", 64'(bram_we_out), 64'd1);
        chk("t2_host_addr", 64'(bram_addr_out), 64'd100);
        chk("t2_gnt_after", 64'(core_gnt_out), 64'd0);

        // Simultaneous requests from IDLE: host wins.
        do_reset();
        host_busy_in = 1'b1;
        core_req_in  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("t3_gnt_host%0d", k), 64'(core_gnt_out), 64'd0);
        end
        host_busy_in = 1'b0;
        tick();
        chk("t3_gnt_idle", 64'(core_gnt_out), 64'd0);
        tick();
        chk("t3_gnt_core", 64'(core_gnt_out), 64'd1);

        // Host write then read-back of addr 7.
        do_reset();
        host_busy_in = 1'b1;
        tick();
        host_we_in    = 1'b1;
        host_addr_in  = 14'd7;
        host_wdata_in = 64'h1234;
        tick();
        host_we_in = 1'b0;
        host_re_in = 1'b1;
        chk("t4_mem7", mem[7], 64'h1234);
        tick();
        host_re_in = 1'b0;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (host_rvalid_out) begin
                pulses++;
                chk("t4_hrdata", host_rdata_out, 64'h1234);
                chk("t4_pulse_pos", 64'(k), 64'd1);
            end
        end
        chk("t4_pulses", 64'(pulses), 64'd1);
        chk("t4_hrdata_held", host_rdata_out, 64'h1234);
        chk("t4_crv", 64'(core_rvalid_out), 64'd0);

        // 300 host writes while the core owns the port.
        do_reset();
        core_req_in = 1'b1;
        tick();
        host_we_in    = 1'b1;
        host_addr_in  = 14'd20;
        host_wdata_in = 64'hBAD;
        wes = 0;
        for (int k = 0; k < 300; k++) begin
            if (bram_we_out) wes++;
            tick();
        end
        host_we_in = 1'b0;
        tick();
        chk("t5_bram_we", 64'(wes), 64'd0);
        chk("t5_mem20", mem[20], 64'h5555_0000);
`ifdef BRAM_ARB_DROP_CHECK_EN
        chk("t5_drop_err", 64'(drop_err_out), 64'd1);
        chk("t5_drop_cnt", 64'(drop_count_out), 64'd255);
`else
        chk("t5_drop_err", 64'(drop_err_out), 64'd0);
        chk("t5_drop_cnt", 64'(drop_count_out), 64'd0);
`endif

        // Reset with two reads in flight.
        do_reset();
        core_req_in = 1'b1;
        tick();
        core_re_in   = 1'b1;
        core_addr_in = 14'd5;
        tick();
        core_re_in = 1'b0;
        tick();
        tick();
        chk("t6_crdata_pre", core_rdata_out, 64'hDEAD);
        core_re_in   = 1'b1;
        core_addr_in = 14'd1;
        tick();
        core_addr_in = 14'd2;
        tick();
        clr_inputs();
        #2;
        rst_in = 1'b1;
        #1;
        chk("t6_gnt", 64'(core_gnt_out), 64'd0);
        chk("t6_en", 64'(bram_en_out), 64'd0);
        chk("t6_crdata", core_rdata_out, 64'd0);
        chk("t6_crv", 64'(core_rvalid_out), 64'd0);
        tick();
        tick();
        rst_in = 1'b0;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (core_rvalid_out || host_rvalid_out) pulses++;
        end
        chk("t6_no_rvalid", 64'(pulses), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
